// File: rtl/mfe_pkg.sv
// Shared types and constants for the parametrised 3x3 window filter engine.
package mfe_pkg;

  typedef enum logic [1:0] {
    MODE_MED  = 2'd0,
    MODE_MIN  = 2'd1,
    MODE_MAX  = 2'd2,
    MODE_PASS = 2'd3
  } mfe_mode_e;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FETCH = 3'd1,
    CALC  = 3'd2,
    WRITE = 3'd3,
    DONE  = 3'd4
  } mfe_state_e;

  // Fetch cycles for the first pixel of a row (full 3x3 load) and for the
  // following pixels (one new column after the window shift).
  localparam int FETCH_FIRST = 9;
  localparam int FETCH_NEXT  = 3;

endpackage

// File: rtl/mfe_sort9.sv
// Combinational 9-input order network: min, median (5th smallest) and max.
// Each tap is ranked against the others with index tie-break, so every tap
// gets a unique rank 0..8 and the outputs are picked by rank.
module mfe_sort9 #(
  parameter int DW = 8
) (
  input  logic [9*DW-1:0] taps,
  output logic [DW-1:0]   vmin,
  output logic [DW-1:0]   vmed,
  output logic [DW-1:0]   vmax
);

  logic [3:0] rank [9];

  // Rank each tap: number of taps ordered strictly before it.
  always_comb begin
    for (int i = 0; i < 9; i++) begin
      rank[i] = 4'd0;
      for (int j = 0; j < 9; j++) begin
        if ((taps[j*DW +: DW] < taps[i*DW +: DW]) ||
            ((taps[j*DW +: DW] == taps[i*DW +: DW]) && (j < i)))
          rank[i] = rank[i] + 4'd1;
      end
    end
  end

  // Select the taps holding rank 0, 4 and 8.
  always_comb begin
    vmin = '0;
    vmed = '0;
    vmax = '0;
    for (int i = 0; i < 9; i++) begin
      if (rank[i] == 4'd0) vmin = taps[i*DW +: DW];
      if (rank[i] == 4'd4) vmed = taps[i*DW +: DW];
      if (rank[i] == 4'd8) vmax = taps[i*DW +: DW];
    end
  end

endmodule

// File: rtl/mfe_param.sv
// mfe_param: streams a raster image from the image ROM, applies a 3x3
// median/min/max/centre filter and writes each result to the result RAM.
// Build option MFE_REPLICATE_EDGE_EN: out-of-image taps use the nearest
// in-image pixel (clamped address issued) instead of zero padding.
module mfe_param
  import mfe_pkg::*;
#(
  parameter int IMG_W = 128,
  parameter int IMG_H = 128,
  parameter int DW    = 8,
  parameter int AW    = $clog2(IMG_W*IMG_H)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          ready,
  output logic          busy,
  input  logic [1:0]    mode,
  output logic [AW-1:0] iaddr,
  input  logic [DW-1:0] idata,
  output logic [AW-1:0] addr,
  output logic [DW-1:0] data_wr,
  input  logic [DW-1:0] data_rd,
  output logic          wen
);

  localparam int XW = $clog2(IMG_W);
  localparam int YW = $clog2(IMG_H);

  mfe_state_e    state;
  mfe_mode_e     mode_q;
  logic [XW-1:0] x, nx;
  logic [YW-1:0] y, ny;
  logic [3:0]    tap, nt;
  logic          last_px, last_tap, issue, shift;
  int            cx, cy;
  logic          pad_n;
  logic [1:0]    col_n, row_n;
  logic [AW-1:0] fetch_addr;
  logic          vld_p0, pad_p0, vld_p1, pad_p1;
  logic [1:0]    col_p0, row_p0, col_p1, row_p1;
  logic [DW-1:0] win     [3][3];
  logic [DW-1:0] win_eff [3][3];
  logic [DW-1:0] tap_in;
  logic [9*DW-1:0] taps;
  logic [DW-1:0] vmin, vmed, vmax;
  logic          unused_rd;

  function automatic int clamp_coord(input int v, input int hi);
    if (v < 0)  return 0;
    if (v > hi) return hi;
    return v;
  endfunction

  assign unused_rd = ^data_rd;
  assign last_px   = (x == XW'(IMG_W-1)) && (y == YW'(IMG_H-1));
  assign last_tap  = (x == '0) ? (tap == 4'(FETCH_FIRST-1)) : (tap == 4'(FETCH_NEXT-1));
  assign issue     = ((state == IDLE) && ready) ||
                     ((state == FETCH) && !last_tap) ||
                     ((state == WRITE) && !last_px);
  assign shift     = (state == WRITE) && !last_px && (nx != '0);

  // Position and tap index of the fetch cycle that follows this one.
  always_comb begin
    nx = x;
    ny = y;
    nt = tap + 4'd1;
    if (state == WRITE) begin
      nt = '0;
      if (x == XW'(IMG_W-1)) begin
        nx = '0;
        ny = y + 1'b1;
      end else begin
        nx = x + 1'b1;
      end
    end else if (state != FETCH) begin
      nx = '0;
      ny = '0;
      nt = '0;
    end
  end

  // Window slot, image coordinate and ROM address of the next fetch.
  always_comb begin
    if (nx == '0) begin
      col_n = 2'(int'(nt) / 3);
      row_n = 2'(int'(nt) % 3);
    end else begin
      col_n = 2'd2;
      row_n = nt[1:0];
    end
    cx = int'(nx) + int'(col_n) - 1;
    cy = int'(ny) + int'(row_n) - 1;
`ifdef MFE_REPLICATE_EDGE_EN
    pad_n = 1'b0;
    cx    = clamp_coord(cx, IMG_W-1);
    cy    = clamp_coord(cy, IMG_H-1);
`else
    pad_n = (cx < 0) || (cx >= IMG_W) || (cy < 0) || (cy >= IMG_H);
`endif
    fetch_addr = AW'(cy*IMG_W + cx);
  end

  // Control FSM: frame sequencing, fetch address issue and result write.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state   <= IDLE;
      mode_q  <= MODE_MED;
      busy    <= 1'b0;
      wen     <= 1'b0;
      iaddr   <= '0;
      addr    <= '0;
      data_wr <= '0;
      x       <= '0;
      y       <= '0;
      tap     <= '0;
      vld_p0  <= 1'b0;
    end else begin
      wen    <= 1'b0;
      vld_p0 <= issue;
      if (issue) begin
        x      <= nx;
        y      <= ny;
        tap    <= nt;
        col_p0 <= col_n;
        row_p0 <= row_n;
        pad_p0 <= pad_n;
        if (!pad_n) iaddr <= fetch_addr;
      end
      case (state)
        IDLE: begin
          if (ready) begin
            busy   <= 1'b1;
            mode_q <= mfe_mode_e'(mode);
            state  <= FETCH;
          end
        end
        FETCH: begin
          if (last_tap) state <= CALC;
        end
        CALC: begin
          wen  <= 1'b1;
          addr <= AW'(int'(y)*IMG_W + int'(x));
          case (mode_q)
            MODE_MED:  data_wr <= vmed;
            MODE_MIN:  data_wr <= vmin;
            MODE_MAX:  data_wr <= vmax;
            MODE_PASS: data_wr <= win_eff[1][1];
          endcase
          state <= WRITE;
        end
        WRITE: begin
          state <= last_px ? DONE : FETCH;
        end
        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // ---- p0 -> p1: ROM data for the address issued last cycle arrives now ----
  always_ff @(posedge clk) begin
    if (!reset) vld_p1 <= 1'b0;
    else        vld_p1 <= vld_p0;
    col_p1 <= col_p0;
    row_p1 <= row_p0;
    pad_p1 <= pad_p0;
  end

  assign tap_in = pad_p1 ? '0 : idata;

  // Window as seen this cycle, with the arriving tap bypassed in.
  always_comb begin
    win_eff = win;
    if (vld_p1) win_eff[col_p1][row_p1] = tap_in;
  end

  // Window storage: shift left between pixels, otherwise capture arriving taps.
  always_ff @(posedge clk) begin
    if (shift) begin
      for (int r = 0; r < 3; r++) begin
        win[0][r] <= win[1][r];
        win[1][r] <= win[2][r];
      end
    end else if (vld_p1) begin
      win[col_p1][row_p1] <= tap_in;
    end
  end

  for (genvar c = 0; c < 3; c++) begin : g_col
    for (genvar r = 0; r < 3; r++) begin : g_row
      assign taps[(c*3+r)*DW +: DW] = win_eff[c][r];
    end
  end

  mfe_sort9 #(.DW(DW)) u_sort9 (
    .taps (taps),
    .vmin (vmin),
    .vmed (vmed),
    .vmax (vmax)
  );

endmodule

// File: tb/tb_mfe_param.sv
// Scoreboard bench for mfe_param on a 4x4 image: stimulus pushes expected
// writes, a negedge monitor pops and compares on every wen.
module tb_mfe_param;

  localparam int W  = 4;
  localparam int H  = 4;
  localparam int DW = 8;
  localparam int AW = 4;
  localparam int BUSY_CYC = H*(11+(W-1)*5) + 1;

  typedef struct packed {
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } wr_t;

  logic          clk = 1'b0;
  logic          reset, ready;
  logic [1:0]    mode;
  logic          busy, wen;
  logic [AW-1:0] iaddr, addr;
  logic [DW-1:0] idata, data_wr;
  logic [DW-1:0] data_rd = '0;
  logic [DW-1:0] img [W*H];

  wr_t exp_q [$];
  wr_t e;
  int  checks = 0;
  int  errors = 0;
  int  wr_cnt = 0;

  mfe_param #(.IMG_W(W), .IMG_H(H), .DW(DW)) dut (
    .clk     (clk),
    .reset   (reset),
    .ready   (ready),
    .busy    (busy),
    .mode    (mode),
    .iaddr   (iaddr),
    .idata   (idata),
    .addr    (addr),
    .data_wr (data_wr),
    .data_rd (data_rd),
    .wen     (wen)
  );

  always #5 clk = ~clk;

  // Image ROM with one cycle read latency.
  always @(posedge clk) idata <= img[iaddr];

  // Monitor: every write is checked against the head of the scoreboard.
  always @(negedge clk) begin
    if (reset === 1'b1 && wen === 1'b1) begin
      wr_cnt++;
      checks++;
      if (busy !== 1'b1) begin
        errors++;
        $display("FAIL wen_busy: write at addr %0d while busy=%b, required busy=1", addr, busy);
      end
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_write: addr=%0d data=%0h, required no write", addr, data_wr);
      end else begin
        e = exp_q.pop_front();
        if (addr !== e.a || data_wr !== e.d) begin
          errors++;
          $display("FAIL write: addr=%0d data=%0h, required addr=%0d data=%0h",
                   addr, data_wr, e.a, e.d);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0d, required %0d", name, act, req);
    end
  endtask

  function automatic logic [DW-1:0] model_px(input int x, input int y, input int m);
    logic [DW-1:0] t [9];
    logic [DW-1:0] tmp;
    int k, cx, cy;
    k = 0;
    for (int dy = -1; dy <= 1; dy++) begin
      for (int dx = -1; dx <= 1; dx++) begin
        cx = x + dx;
        cy = y + dy;
`ifdef MFE_REPLICATE_EDGE_EN
        if (cx < 0) cx = 0;
        if (cx > W-1) cx = W-1;
        if (cy < 0) cy = 0;
        if (cy > H-1) cy = H-1;
        t[k] = img[cy*W+cx];
`else
        if (cx < 0 || cx >= W || cy < 0 || cy >= H) t[k] = '0;
        else t[k] = img[cy*W+cx];
`endif
        k++;
      end
    end
    for (int i = 0; i < 9; i++)
      for (int j = 0; j < 8-i; j++)
        if (t[j] > t[j+1]) begin
          tmp = t[j]; t[j] = t[j+1]; t[j+1] = tmp;
        end
    case (m)
      0: return t[4];
      1: return t[0];
      2: return t[8];
      default: return img[y*W+x];
    endcase
  endfunction

  task automatic push_model(input int m);
    wr_t w;
    for (int i = 0; i < W*H; i++) begin
      w.a = AW'(i);
      w.d = model_px(i % W, i / W, m);
      exp_q.push_back(w);
    end
  endtask

  // Hand-derived results for the constant 0x80 image.
  task automatic push_const(input int m);
    wr_t w;
    logic [15:0] mask;
`ifdef MFE_REPLICATE_EDGE_EN
    mask = 16'hFFFF;
`else
    case (m)
      0:       mask = 16'h6FF6;
      1:       mask = 16'h0660;
      default: mask = 16'hFFFF;
    endcase
`endif
    for (int i = 0; i < W*H; i++) begin
      w.a = AW'(i);
      w.d = mask[i] ? 8'h80 : 8'h00;
      exp_q.push_back(w);
    end
  endtask

  task automatic start_frame(input logic [1:0] m, input string name);
    int guard;
    @(negedge clk);
    mode  = m;
    ready = 1'b1;
    guard = 0;
    while (busy !== 1'b1 && guard < 10) begin
      @(negedge clk);
      guard++;
    end
    chk({name, "_start"}, busy, 1);
  endtask

  task automatic wait_busy_low(input string name);
    int cyc;
    cyc = 0;
    while (busy === 1'b1 && cyc < 1000) begin
      @(negedge clk);
      cyc++;
    end
    chk({name, "_busy_cycles"}, cyc, BUSY_CYC);
  endtask

  task automatic run_frame(input logic [1:0] m, input string name);
    wr_cnt = 0;
    start_frame(m, name);
    ready = 1'b0;
    wait_busy_low(name);
    repeat (2) @(negedge clk);
    chk({name, "_pending"}, exp_q.size(), 0);
    chk({name, "_writes"}, wr_cnt, W*H);
  endtask

  initial begin
    int bad, gap;
    reset = 1'b0;
    ready = 1'b0;
    mode  = 2'd0;
    for (int i = 0; i < W*H; i++) img[i] = 8'h80;

    // Reset and idle
    repeat (2) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_wen", wen, 0);
    chk("rst_iaddr", iaddr, 0);
    chk("rst_addr", addr, 0);
    chk("rst_data_wr", data_wr, 0);
    reset = 1'b1;
    bad = 0;
    repeat (100) begin
      @(negedge clk);
      if (busy !== 1'b0 || wen !== 1'b0) bad++;
    end
    chk("idle_quiet", bad, 0);

    // Constant image, min / max / median
    push_const(1); run_frame(2'd1, "const_min");
    push_const(2); run_frame(2'd2, "const_max");
    push_const(0); run_frame(2'd0, "const_med");

    // Ramp image, centre pass: output equals input
    for (int i = 0; i < W*H; i++) img[i] = 8'(i);
    for (int i = 0; i < W*H; i++) begin
      e.a = AW'(i);
      e.d = 8'(i);
      exp_q.push_back(e);
    end
    run_frame(2'd3, "ramp_pass");

    // Scrambled image through every order statistic
    for (int i = 0; i < W*H; i++) img[i] = 8'((i*73 + 29) & 8'hFF);
    push_model(0); run_frame(2'd0, "pat_med");
    push_model(1); run_frame(2'd1, "pat_min");
    push_model(2); run_frame(2'd2, "pat_max");

    // Reset in the middle of a frame abandons it
    push_model(0);
    start_frame(2'd0, "abort");
    ready = 1'b0;
    repeat (40) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    exp_q.delete();
    chk("abort_busy", busy, 0);
    chk("abort_wen", wen, 0);
    wr_cnt = 0;
    repeat (150) @(negedge clk);
    chk("abort_no_writes", wr_cnt, 0);
    push_model(1); run_frame(2'd1, "after_abort");

    // ready held high: back-to-back frames, mode change applies to frame 2
    push_model(0);
    push_model(2);
    wr_cnt = 0;
    start_frame(2'd0, "b2b1");
    mode = 2'd2;
    wait_busy_low("b2b1");
    gap = 0;
    while (busy !== 1'b1 && gap < 10) begin
      @(negedge clk);
      gap++;
    end
    chk("b2b_gap", gap, 1);
    ready = 1'b0;
    wait_busy_low("b2b2");
    repeat (2) @(negedge clk);
    chk("b2b_pending", exp_q.size(), 0);
    chk("b2b_writes", wr_cnt, 2*W*H);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
